// File: rtl/sram8k_pwr_arb_ctrl.sv
// Two-requester arbiter and power-mode sequencer for one 8K x 20 single-port SRAM macro.
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed R0-over-R1 priority instead of round-robin.
module sram8k_pwr_arb_ctrl #(
    parameter int AW       = 13,
    parameter int DW       = 20,
    parameter int IDLE_CYC = 256,
    parameter int WAKE_TO  = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_a,
    input  logic [DW-1:0] r0_d,
    input  logic [DW-1:0] r0_bweb,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_q,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_a,
    input  logic [DW-1:0] r1_d,
    input  logic [DW-1:0] r1_bweb,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_q,
    input  logic          pwr_sd_req,
    output logic [2:0]    pwr_state,
    output logic          wake_err,
    output logic          m_ceb,
    output logic          m_web,
    output logic [AW-1:0] m_a,
    output logic [DW-1:0] m_d,
    output logic [DW-1:0] m_bweb,
    output logic          m_sd,
    output logic          m_dslp,
    input  logic [DW-1:0] m_q,
    input  logic          m_pudelay_sd,
    input  logic          m_pudelay_dslp
);

    typedef enum logic [2:0] {
        ST_ACTIVE  = 3'd0,
        ST_DSLP    = 3'd1,
        ST_WAKE_DS = 3'd2,
        ST_SD      = 3'd3,
        ST_WAKE_SD = 3'd4
    } state_t;

    localparam int ICW = $clog2(IDLE_CYC + 1);
    localparam int WCW = $clog2(WAKE_TO + 1);

    state_t         state;
    state_t         state_next;
    logic [ICW-1:0] idle_cnt;
    logic [ICW-1:0] idle_next;
    logic [WCW-1:0] wake_cnt;
    logic [WCW-1:0] wake_next;
    logic           err_next;
    logic           p1_v, p1_rd, p1_own;
    logic           p2_v, p2_rd, p2_own;
    logic           any_req;
    logic           pipe_empty;
    logic           can_grant;
    logic           gnt_any;
    logic           sel_we;
    logic           wake_pd;

    assign any_req    = r0_req | r1_req;
    assign pipe_empty = ~p1_v & ~p2_v;
    assign can_grant  = (state == ST_ACTIVE) & ~pwr_sd_req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign r0_gnt = can_grant & r0_req;
    assign r1_gnt = can_grant & r1_req & ~r0_req;
`else
    // rr_r1 set means R1 wins the next tie, i.e. R0 was granted last.
    logic rr_r1;

    assign r0_gnt = can_grant & r0_req & ~(r1_req & rr_r1);
    assign r1_gnt = can_grant & r1_req & (~r0_req | rr_r1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_r1 <= 1'b0;
        end else if (r0_gnt) begin
            rr_r1 <= 1'b1;
        end else if (r1_gnt) begin
            rr_r1 <= 1'b0;
        end
    end
`endif

    assign gnt_any = r0_gnt | r1_gnt;
    assign sel_we  = r1_gnt ? r1_we : r0_we;
    assign wake_pd = (state == ST_WAKE_DS) ? m_pudelay_dslp : m_pudelay_sd;

    // Shutdown request outranks traffic, which outranks idle sleep.
    always_comb begin
        state_next = state;
        idle_next  = '0;
        wake_next  = '0;
        err_next   = wake_err;
        case (state)
            ST_ACTIVE: begin
                idle_next = idle_cnt;
                if (pwr_sd_req) begin
                    idle_next = '0;
                    if (pipe_empty) begin
                        state_next = ST_SD;
                    end
                end else if (any_req) begin
                    idle_next = '0;
                end else if (pipe_empty) begin
                    if (idle_cnt == ICW'(IDLE_CYC - 1)) begin
                        state_next = ST_DSLP;
                        idle_next  = '0;
                    end else begin
                        idle_next = idle_cnt + ICW'(1);
                    end
                end
            end
            ST_DSLP: begin
                if (pwr_sd_req) begin
                    state_next = ST_SD;
                end else if (any_req) begin
                    state_next = ST_WAKE_DS;
                end
            end
            ST_WAKE_DS, ST_WAKE_SD: begin
                if (pwr_sd_req) begin
                    state_next = ST_SD;
                end else if (!wake_pd) begin
                    state_next = ST_ACTIVE;
                end else if (wake_cnt == WCW'(WAKE_TO - 1)) begin
                    state_next = ST_ACTIVE;
                    err_next   = 1'b1;
                end else begin
                    wake_next = wake_cnt + WCW'(1);
                end
            end
            ST_SD: begin
                if (!pwr_sd_req) begin
                    state_next = ST_WAKE_SD;
                end
            end
            default: state_next = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
            wake_err <= 1'b0;
        end else begin
            state    <= state_next;
            idle_cnt <= idle_next;
            wake_cnt <= wake_next;
            wake_err <= err_next;
        end
    end

    // Macro pins are registered; address and data hold between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ceb  <= 1'b1;
            m_web  <= 1'b1;
            m_bweb <= '1;
            m_a    <= '0;
            m_d    <= '0;
            m_sd   <= 1'b0;
            m_dslp <= 1'b0;
        end else begin
            m_sd   <= (state_next == ST_SD);
            m_dslp <= (state_next == ST_DSLP);
            if (gnt_any) begin
                m_ceb  <= 1'b0;
                m_web  <= ~sel_we;
                m_a    <= r1_gnt ? r1_a : r0_a;
                m_d    <= r1_gnt ? r1_d : r0_d;
                m_bweb <= r1_gnt ? r1_bweb : r0_bweb;
            end else begin
                m_ceb  <= 1'b1;
                m_web  <= 1'b1;
                m_bweb <= '1;
            end
        end
    end

    // Stage 1 is the macro sample cycle, stage 2 is when read data appears on m_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_v   <= 1'b0;
            p1_rd  <= 1'b0;
            p1_own <= 1'b0;
            p2_v   <= 1'b0;
            p2_rd  <= 1'b0;
            p2_own <= 1'b0;
        end else begin
            p1_v   <= gnt_any;
            p1_rd  <= ~sel_we;
            p1_own <= r1_gnt;
            p2_v   <= p1_v;
            p2_rd  <= p1_rd;
            p2_own <= p1_own;
        end
    end

    assign r0_rvalid = p2_v & p2_rd & ~p2_own;
    assign r1_rvalid = p2_v & p2_rd & p2_own;
    assign r0_q      = m_q;
    assign r1_q      = m_q;
    assign pwr_state = state;

endmodule

// File: tb/tb_sram8k_pwr_arb_ctrl.sv
// Randomized bench for sram8k_pwr_arb_ctrl with a behavioural SRAM macro and a transaction-level reference model.
module tb_sram8k_pwr_arb_ctrl;

    localparam int AW       = 13;
    localparam int DW       = 20;
    localparam int IDLE_CYC = 256;
    localparam int WAKE_TO  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_req, r0_we, r0_gnt, r0_rvalid;
    logic          r1_req, r1_we, r1_gnt, r1_rvalid;
    logic [AW-1:0] r0_a, r1_a;
    logic [DW-1:0] r0_d, r1_d, r0_bweb, r1_bweb, r0_q, r1_q;
    logic          pwr_sd_req;
    logic [2:0]    pwr_state;
    logic          wake_err;
    logic          m_ceb, m_web, m_sd, m_dslp;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d, m_bweb;
    logic [DW-1:0] m_q = '0;
    logic          m_pudelay_sd, m_pudelay_dslp;

    always #5 clk = ~clk;

    sram8k_pwr_arb_ctrl #(
        .AW(AW), .DW(DW), .IDLE_CYC(IDLE_CYC), .WAKE_TO(WAKE_TO)
    ) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_a(r0_a), .r0_d(r0_d), .r0_bweb(r0_bweb),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_q(r0_q),
        .r1_req(r1_req), .r1_we(r1_we), .r1_a(r1_a), .r1_d(r1_d), .r1_bweb(r1_bweb),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_q(r1_q),
        .pwr_sd_req(pwr_sd_req), .pwr_state(pwr_state), .wake_err(wake_err),
        .m_ceb(m_ceb), .m_web(m_web), .m_a(m_a), .m_d(m_d), .m_bweb(m_bweb),
        .m_sd(m_sd), .m_dslp(m_dslp), .m_q(m_q),
        .m_pudelay_sd(m_pudelay_sd), .m_pudelay_dslp(m_pudelay_dslp)
    );

    // Behavioural single-port macro: samples its pins at the rising edge.
    logic [DW-1:0] mac_mem [0:(1<<AW)-1] = '{default: '0};

    always @(posedge clk) begin
        if (!m_ceb && !m_sd && !m_dslp) begin
            if (!m_web) begin
                mac_mem[m_a] <= (mac_mem[m_a] & m_bweb) | (m_d & ~m_bweb);
            end else begin
                m_q <= mac_mem[m_a];
            end
        end
    end

    typedef struct {
        int            due;
        int            owner;
        logic [DW-1:0] data;
    } rd_exp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_gnt;
    int            mode, idle_c, wake_c;
    bit            m_err, favor1;
    bit            exp_g0, exp_g1, exp_ceb, exp_web;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d, exp_bweb;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
    rd_exp_t       rd_q[$];

    bit            pend [2];
    bit            p_we [2];
    logic [AW-1:0] p_a [2];
    logic [DW-1:0] p_d [2];
    logic [DW-1:0] p_bweb [2];
    int            req_pct [2];
    bit            read_only, sd_random, pd_random;
    bit            sd_lvl, pd_ds_lvl, pd_sd_lvl;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        if (obs !== req) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, req);
        end
    endtask

    task automatic queueReq(input int n, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] bweb);
        pend[n]   = 1'b1;
        p_we[n]   = we;
        p_a[n]    = a;
        p_d[n]    = d;
        p_bweb[n] = bweb;
    endtask

    task automatic driveSignals();
        r0_req = pend[0]; r0_we = p_we[0]; r0_a = p_a[0]; r0_d = p_d[0]; r0_bweb = p_bweb[0];
        r1_req = pend[1]; r1_we = p_we[1]; r1_a = p_a[1]; r1_d = p_d[1]; r1_bweb = p_bweb[1];
        pwr_sd_req     = sd_lvl;
        m_pudelay_dslp = pd_ds_lvl;
        m_pudelay_sd   = pd_sd_lvl;
    endtask

    task automatic applyStimulus();
        for (int n = 0; n < 2; n++) begin
            if (!pend[n] && ($urandom_range(99) < req_pct[n])) begin
                queueReq(n, read_only ? 1'b0 : 1'($urandom_range(1)), AW'($urandom_range(15)),
                         DW'($urandom()), DW'($urandom()));
            end
        end
        if (sd_random && ($urandom_range(99) < 2)) sd_lvl = !sd_lvl;
        if (pd_random) begin
            pd_ds_lvl = ($urandom_range(99) < 60);
            pd_sd_lvl = ($urandom_range(99) < 60);
        end
        driveSignals();
    endtask

    task automatic modelReset();
        mode = 0; idle_c = 0; wake_c = 0; m_err = 0; favor1 = 0;
        last_gnt = cyc - 10;
        rd_q.delete();
        exp_ceb = 1; exp_web = 1; exp_bweb = '1; exp_a = '0; exp_d = '0;
        pend[0] = 0; pend[1] = 0;
    endtask

    // Arbitration rule: grants only in ACTIVE without a shutdown request.
    task automatic modelGrant();
        exp_g0 = 0;
        exp_g1 = 0;
        if (mode == 0 && !sd_lvl) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            if (pend[0]) exp_g0 = 1;
            else if (pend[1]) exp_g1 = 1;
`else
            if (pend[0] && pend[1]) begin
                if (favor1) exp_g1 = 1;
                else exp_g0 = 1;
            end else if (pend[0]) exp_g0 = 1;
            else if (pend[1]) exp_g1 = 1;
`endif
        end
    endtask

    task automatic modelAdvance();
        bit busy, any, pd;
        int n;
        busy = (cyc - last_gnt) <= 2;
        any  = pend[0] | pend[1];
        if (exp_g0 || exp_g1) begin
            n        = exp_g0 ? 0 : 1;
            favor1   = exp_g0;
            last_gnt = cyc;
            exp_ceb  = 0;
            exp_web  = !p_we[n];
            exp_a    = p_a[n];
            exp_d    = p_d[n];
            exp_bweb = p_bweb[n];
            if (p_we[n]) ref_mem[p_a[n]] = (ref_mem[p_a[n]] & p_bweb[n]) | (p_d[n] & ~p_bweb[n]);
            else rd_q.push_back('{due: cyc + 2, owner: n, data: ref_mem[p_a[n]]});
            pend[n] = 0;
        end else begin
            exp_ceb = 1; exp_web = 1; exp_bweb = '1;
        end
        case (mode)
            0: begin
                if (sd_lvl) begin
                    idle_c = 0;
                    if (!busy) mode = 3;
                end else if (any) idle_c = 0;
                else if (!busy) begin
                    idle_c++;
                    if (idle_c == IDLE_CYC) begin mode = 1; idle_c = 0; end
                end
            end
            1: begin
                if (sd_lvl) mode = 3;
                else if (any) begin mode = 2; wake_c = 0; end
            end
            2, 4: begin
                pd = (mode == 2) ? pd_ds_lvl : pd_sd_lvl;
                if (sd_lvl) mode = 3;
                else if (!pd) mode = 0;
                else begin
                    wake_c++;
                    if (wake_c == WAKE_TO) begin m_err = 1; mode = 0; end
                end
            end
            3: if (!sd_lvl) begin mode = 4; wake_c = 0; end
            default: mode = 0;
        endcase
    endtask

    task automatic checkRegistered();
        bit            ev0, ev1;
        logic [DW-1:0] edata;
        ev0 = 0; ev1 = 0; edata = '0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            if (rd_q[0].owner == 0) ev0 = 1;
            else ev1 = 1;
            edata = rd_q[0].data;
            void'(rd_q.pop_front());
        end
        checkOutput("pwr_state", 32'(pwr_state), mode);
        checkOutput("m_dslp", 32'(m_dslp), 32'(mode == 1));
        checkOutput("m_sd", 32'(m_sd), 32'(mode == 3));
        checkOutput("wake_err", 32'(wake_err), 32'(m_err));
        checkOutput("m_ceb", 32'(m_ceb), 32'(exp_ceb));
        checkOutput("m_web", 32'(m_web), 32'(exp_web));
        checkOutput("m_a", 32'(m_a), 32'(exp_a));
        checkOutput("m_d", 32'(m_d), 32'(exp_d));
        checkOutput("m_bweb", 32'(m_bweb), 32'(exp_bweb));
        checkOutput("r0_rvalid", 32'(r0_rvalid), 32'(ev0));
        checkOutput("r1_rvalid", 32'(r1_rvalid), 32'(ev1));
        if (ev0) checkOutput("r0_q", 32'(r0_q), 32'(edata));
        if (ev1) checkOutput("r1_q", 32'(r1_q), 32'(edata));
    endtask

    task automatic runCycles(input int num);
        for (int i = 0; i < num; i++) begin
            applyStimulus();
            #1;
            modelGrant();
            checkOutput("r0_gnt", 32'(r0_gnt), 32'(exp_g0));
            checkOutput("r1_gnt", 32'(r1_gnt), 32'(exp_g1));
            modelAdvance();
            @(posedge clk);
            #1;
            cyc++;
            checkRegistered();
        end
    endtask

    task automatic midReset();
        #3;
        rst = 1'b1;
        #1;
        modelReset();
        driveSignals();
        checkRegistered();
        @(posedge clk);
        #1;
        checkRegistered();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_pct[0] = 0; req_pct[1] = 0;
        read_only = 0; sd_random = 0; pd_random = 0;
        sd_lvl = 0; pd_ds_lvl = 0; pd_sd_lvl = 0;
        for (int n = 0; n < 2; n++) begin
            p_we[n] = 0; p_a[n] = '0; p_d[n] = '0; p_bweb[n] = '1;
        end
        modelReset();
        driveSignals();
        repeat (3) @(posedge clk);
        #1;
        checkRegistered();
        checkOutput("rst_gnt0", 32'(r0_gnt), 0);
        checkOutput("rst_gnt1", 32'(r1_gnt), 0);
        rst = 1'b0;
        modelReset();

        // Directed write then read-back of 0x0ABC.
        queueReq(0, 1'b1, 13'h0ABC, 20'h5A5A5, 20'h00000);
        runCycles(1);
        queueReq(0, 1'b0, 13'h0ABC, 20'h00000, 20'hFFFFF);
        runCycles(4);

        // Both requesters saturated: one grant every cycle.
        req_pct[0] = 100; req_pct[1] = 100;
        runCycles(24);

        // Idle into deep sleep, then wake on an R1 request.
        req_pct[0] = 0; req_pct[1] = 0;
        pd_ds_lvl = 1;
        runCycles(IDLE_CYC + 6);
        queueReq(1, 1'b0, 13'h0ABC, 20'h0, 20'hFFFFF);
        runCycles(6);
        pd_ds_lvl = 0;
        runCycles(5);

        // Shutdown during a read burst, then power back up.
        read_only = 1;
        req_pct[0] = 100; req_pct[1] = 100;
        runCycles(8);
        sd_lvl = 1;
        runCycles(8);
        sd_lvl = 0;
        pd_sd_lvl = 1;
        runCycles(4);
        pd_sd_lvl = 0;
        runCycles(6);

        // Wake timeout with PUDELAY held high.
        read_only = 0;
        req_pct[0] = 0; req_pct[1] = 0;
        runCycles(8);
        pd_ds_lvl = 1;
        runCycles(IDLE_CYC + 2);
        queueReq(0, 1'b1, 13'h0123, 20'hABCDE, 20'h0);
        runCycles(WAKE_TO + 6);
        pd_ds_lvl = 0;
        runCycles(10);

        // Random traffic with random shutdown requests and wake delays.
        req_pct[0] = 40; req_pct[1] = 30;
        sd_random = 1; pd_random = 1;
        runCycles(2000);
        sd_random = 0; pd_random = 0;
        sd_lvl = 0; pd_ds_lvl = 0; pd_sd_lvl = 0;
        req_pct[0] = 0; req_pct[1] = 0;
        runCycles(12);

        // Reset between a read grant and its RVALID.
        queueReq(0, 1'b0, 13'h0ABC, 20'h0, 20'hFFFFF);
        runCycles(1);
        midReset();
        runCycles(5);

        // Reset while in shutdown.
        sd_lvl = 1;
        runCycles(4);
        sd_lvl = 0;
        midReset();
        runCycles(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
